// File: rtl/ram_word_bridge.sv
// Bridges a 16-bit req/ack bus master onto the byte-wide, negedge-sampled system RAM.
// Each word access becomes two little-endian byte accesses (low byte first).
module ram_word_bridge #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req,
    input  logic              we,
    input  logic              word,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       wdata,
    output logic [15:0]       rdata,
    output logic              ack,
    output logic              busy,
    output logic              ram_cs,
    output logic              ram_oe,
    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_din,
    input  logic [7:0]        ram_q
);

    typedef enum logic [1:0] {IDLE, B0, B1, DONE} state_t;

    state_t     state;
    logic       we_r;
    logic       word_r;
    logic [7:0] wdata_hi;

    // Request attributes are only sampled in IDLE; they carry no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && req) begin
            we_r     <= we;
            word_r   <= word;
            wdata_hi <= wdata[15:8];
        end
    end

    assign ram_oe = ram_cs & ~ram_wr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            ack      <= 1'b0;
            busy     <= 1'b0;
            ram_cs   <= 1'b0;
            ram_wr   <= 1'b0;
            ram_addr <= '0;
            ram_din  <= 8'h00;
            rdata    <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    ack <= 1'b0;
                    if (req) begin
                        state    <= B0;
                        busy     <= 1'b1;
                        ram_cs   <= 1'b1;
                        ram_wr   <= we;
                        ram_addr <= addr;
                        ram_din  <= wdata[7:0];
                    end else begin
                        busy   <= 1'b0;
                        ram_cs <= 1'b0;
                        ram_wr <= 1'b0;
                    end
                end
                // The RAM has completed the low-byte access on the negedge inside B0.
                B0: begin
                    if (!we_r) rdata[7:0] <= ram_q;
                    if (word_r) begin
                        ram_addr <= ram_addr + ADDR_W'(1);
                        ram_din  <= wdata_hi;
                        state    <= B1;
                    end else begin
                        ram_cs <= 1'b0;
                        ram_wr <= 1'b0;
                        if (!we_r) rdata[15:8] <= 8'h00;
                        ack    <= 1'b1;
                        state  <= DONE;
                    end
                end
                B1: begin
                    if (!we_r) rdata[15:8] <= ram_q;
                    ram_cs <= 1'b0;
                    ram_wr <= 1'b0;
                    ack    <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    ack   <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    ack    <= 1'b0;
                    busy   <= 1'b0;
                    ram_cs <= 1'b0;
                    ram_wr <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ram_word_bridge.md
Name: ram_word_bridge

Overview:
- Bridges a 16-bit request/acknowledge bus master (CPU/DSP side) onto the byte-wide, negedge-sampled system RAM.
- Splits each word access into two sequential byte accesses, little-endian.
- Drives the RAM's cs/oe/wr/addr/din and captures its Q output.
- Sits directly upstream of the RAM: the RAM's only master on that port.

Parameters:
ADDR_W, 16, byte address width; must equal the RAM's address width.

Ports:
clk  in  1  system clock; the RAM samples on negedge, this block on posedge.
resetn  in  1  asynchronous active-low reset.
req  in  1  access request; held high by the master until ack.
we  in  1  1 = write, 0 = read; sampled with req.
word  in  1  1 = 16-bit access, 0 = 8-bit access.
addr  in  ADDR_W  byte address of the low byte.
wdata  in  16  write data; byte access uses wdata[7:0].
rdata  out  16  read data; valid while ack=1.
ack  out  1  one-cycle completion pulse.
busy  out  1  high whenever state != IDLE.
ram_cs  out  1  RAM chip select.
ram_oe  out  1  RAM output enable; equals ram_cs & ~ram_wr.
ram_wr  out  1  RAM write strobe.
ram_addr  out  ADDR_W  RAM byte address.
ram_din  out  8  RAM write data.
ram_q  in  8  RAM read data; updated by the RAM on negedge.

Behaviour:
Reset and outputs
- resetn=0 forces immediately: state=IDLE; ack=0; busy=0; ram_cs=0; ram_wr=0; ram_oe=0; ram_addr=0; ram_din=0; rdata=0.
- All outputs are registered on posedge clk; ram_oe is derived from registered bits only.

State machine: IDLE, B0, B1, DONE
- IDLE, req=1 at posedge:
  - latch we, word, addr, wdata;
  - ram_cs=1, ram_wr=we, ram_addr=addr, ram_din=wdata[7:0];
  - go to B0.
- IDLE, req=0: remain in IDLE; ram_cs=0.
- B0 (the RAM performs the byte access on the negedge inside this cycle). At the next posedge:
  - read: rdata[7:0] <= ram_q;
  - word=1: ram_addr <= addr+1, wrapping modulo 2^ADDR_W (addr=all-ones gives 0); ram_din <= wdata[15:8]; go to B1.
  - word=0: ram_cs <= 0, ram_wr <= 0; rdata[15:8] <= 0 on a read; go to DONE.
- B1: at the next posedge:
  - read: rdata[15:8] <= ram_q;
  - ram_cs <= 0, ram_wr <= 0; go to DONE.
- DONE: ack=1 for exactly this cycle. At the next posedge, ack <= 0 and state goes to IDLE.
- rdata holds its value until the next read completes. Writes leave rdata unchanged.

Latency (req first sampled at edge E0)
- Byte access: ack high in the cycle after E1.
- Word access: ack high in the cycle after E2.
- Minimum request spacing is E0 to E0+3 for byte and E0 to E0+4 for word, because one IDLE cycle follows each DONE.

Handshake
- Inputs are latched only in IDLE; changes to we/word/addr/wdata while busy=1 are ignored.
- If req is still high in IDLE after ack, a new transaction starts at that edge; the master must drop req in the ack cycle to avoid this.
- Odd addresses are legal; no alignment restriction.

Reset mid-operation
- The bus returns to idle at once and no ack is issued.
- A write byte whose negedge has not yet occurred is not performed. Earlier bytes stay written.

Invariants
- ram_cs=1 only in B0/B1.
- ram_wr=1 implies ram_cs=1.
- ack and busy=0 never coincide with ram_cs=1.

Test Plan:
- Byte write then read: write addr=0x1234, wdata=0x00A5, word=0, then read the same address -> ram_wr high for 1 cycle; ack 2 cycles after req; rdata=0x00A5.
- Word write/read little-endian: write 0xBEEF at 0x0100, word=1 -> RAM[0x0100]=0xEF, RAM[0x0101]=0xBE. Read it back -> rdata=0xBEEF, ack 3 cycles after req.
- Address wrap: word write 0x1122 at 0xFFFF (ADDR_W=16) -> RAM[0xFFFF]=0x22, RAM[0x0000]=0x11, ram_addr sequence FFFF then 0000. Read -> 0x1122.
- Back-to-back with req held high: two byte reads (0x0010=0x33, then 0x0011=0x44) -> ack pulses exactly 3 cycles apart; rdata 0x0033 then 0x0044. Inputs changed mid-access do not alter the first result.
- Reset mid-word-write: assert resetn=0 during B1 of a write of 0x5566 at 0x0200 -> ram_cs, ack, busy drop immediately; RAM[0x0200]=0x66; RAM[0x0201] unchanged (0x00 with a zeroed RAM); the next transaction after release completes normally.
- Invariant checks throughout: ram_oe == ram_cs & ~ram_wr; ack is never high for 2 consecutive cycles; no ram_cs while IDLE.
